// File: rtl/ccg_resp_compactor_pkg.sv
// Shared harness definitions for the CCGRCG response path: run-state encoding
// and default widths/constants, also used by the upstream stimulus sequencer.
package ccg_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ccg_state_e;

  localparam int unsigned CCG_OUT_W   = 18;
  localparam int unsigned CCG_SIG_W   = 32;
  localparam int unsigned CCG_VEC_CNT = 64;
  localparam logic [31:0] CCG_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CCG_SEED    = 32'hFFFFFFFF;

endpackage

// File: rtl/ccg_resp_compactor_misr.sv
// Multiple-input signature register: seed load, single-step fold of a data word,
// and the step result exposed so the owner can capture the post-fold value.
module ccg_misr #(
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] step_val
);

  logic [SIG_W-1:0] misr_q;
  logic [SIG_W-1:0] misr_d;
  logic [SIG_W-1:0] fb_s;

  // Shift left, fold in the polynomial when the MSB falls off, then xor the data word.
  always_comb begin
    fb_s     = {SIG_W{1'b0}};
    if (misr_q[SIG_W-1]) begin
      fb_s = POLY;
    end else begin
      fb_s = {SIG_W{1'b0}};
    end
    step_val = {misr_q[SIG_W-2:0], 1'b0} ^ fb_s ^ data;
  end

  // Load has priority over a step so a start never folds stale data.
  always_comb begin
    misr_d = misr_q;
    if (load) begin
      misr_d = SEED;
    end else if (en) begin
      misr_d = step_val;
    end else begin
      misr_d = misr_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr_q <= {SIG_W{1'b0}};
    end else begin
      misr_q <= misr_d;
    end
  end

endmodule

// File: rtl/ccg_resp_compactor.sv
// Response compactor: folds netlist output vectors into a MISR, tracks which
// output bits toggled, and holds signature/mask until the harness takes them.
module ccg_resp_compactor
  import ccg_harness_pkg::*;
#(
  parameter int unsigned      OUT_W   = CCG_OUT_W,
  parameter int unsigned      SIG_W   = CCG_SIG_W,
  parameter int unsigned      VEC_CNT = CCG_VEC_CNT,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(CCG_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(CCG_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] signature,
  output logic [OUT_W-1:0] toggle_mask,
  output logic [15:0]      vec_count,
  output logic             busy
);

  // VEC_CNT = 2^16 wraps to 16'hFFFF as the final index, which the 16-bit counter still reaches.
  localparam logic [15:0] LAST_IDX = 16'(VEC_CNT - 32'd1);

  ccg_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0] seen0_q, seen0_d;
  logic [OUT_W-1:0] seen1_q, seen1_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic             in_ready_q, in_ready_d;
  logic             sig_valid_q, sig_valid_d;
  logic             busy_q, busy_d;
  logic             accept_s;
  logic             misr_load_s;
  logic             misr_en_s;
  logic [SIG_W-1:0] data_ext_s;
  logic [SIG_W-1:0] misr_step_s;

  ccg_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load_s),
    .en       (misr_en_s),
    .data     (data_ext_s),
    .step_val (misr_step_s)
  );

  // Run control, toggle tracking and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen0_d     = seen0_q;
    seen1_d     = seen1_q;
    sig_d       = sig_q;
    mask_d      = mask_q;
    misr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    accept_s    = in_valid & in_ready_q;
    data_ext_s  = {SIG_W{1'b0}};
    data_ext_s[OUT_W-1:0] = in_data;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          misr_load_s = 1'b1;
          cnt_d       = 16'd0;
          seen0_d     = {OUT_W{1'b0}};
          seen1_d     = {OUT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          misr_en_s = 1'b1;
          seen1_d   = seen1_q | in_data;
          seen0_d   = seen0_q | ~in_data;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            sig_d   = misr_step_s;
            mask_d  = seen0_d & seen1_d;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (sig_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_RUN);
    sig_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, tracking and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      seen0_q     <= {OUT_W{1'b0}};
      seen1_q     <= {OUT_W{1'b0}};
      sig_q       <= {SIG_W{1'b0}};
      mask_q      <= {OUT_W{1'b0}};
      in_ready_q  <= 1'b0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen0_q     <= seen0_d;
      seen1_q     <= seen1_d;
      sig_q       <= sig_d;
      mask_q      <= mask_d;
      in_ready_q  <= in_ready_d;
      sig_valid_q <= sig_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign sig_valid   = sig_valid_q;
  assign busy        = busy_q;
  assign signature   = sig_q;
  assign toggle_mask = mask_q;
  assign vec_count   = cnt_q;

endmodule

// File: tb/tb_ccg_resp_compactor.sv
// Scoreboard bench: three compactor instances (VEC_CNT=1, VEC_CNT=2, defaults)
// share data/handshake inputs; each has its own start so only the target runs.
module tb_ccg_resp_compactor;

  typedef struct {
    logic [31:0] sig;
    logic [17:0] mask;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic        in_valid = 1'b0;
  logic [17:0] in_data = 18'd0;
  logic        sig_ready = 1'b0;

  logic        rdy [3];
  logic        sv  [3];
  logic        bsy [3];
  logic [31:0] sig [3];
  logic [17:0] msk [3];
  logic [15:0] cnt [3];

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ccg_resp_compactor #(.SEED(32'h0), .VEC_CNT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .sig_valid(sv[0]), .sig_ready(sig_ready), .signature(sig[0]),
    .toggle_mask(msk[0]), .vec_count(cnt[0]), .busy(bsy[0]));

  ccg_resp_compactor #(.SEED(32'h0), .VEC_CNT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .sig_valid(sv[1]), .sig_ready(sig_ready), .signature(sig[1]),
    .toggle_mask(msk[1]), .vec_count(cnt[1]), .busy(bsy[1]));

  ccg_resp_compactor dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .sig_valid(sv[2]), .sig_ready(sig_ready), .signature(sig[2]),
    .toggle_mask(msk[2]), .vec_count(cnt[2]), .busy(bsy[2]));

  function automatic logic [31:0] mstep(input logic [31:0] m, input logic [17:0] d);
    logic [31:0] r;
    r = {m[30:0], 1'b0};
    if (m[31]) r = r ^ 32'h04C11DB7;
    return r ^ {14'd0, d};
  endfunction

  // Stand-in for the 6-in/18-out benchmark netlist.
  function automatic logic [17:0] ref_net(input logic [5:0] x);
    logic [5:0] a, b, c;
    a = x ^ {x[0], x[5:1]};
    b = 6'({3'd0, x[2:0]} * {3'd0, x[5:3]});
    c = x + 6'd13;
    return {a, b, c};
  endfunction

  task automatic do_run(input int sel, input logic [31:0] seed, input logic [17:0] data[$],
                        input bit gaps, input int hold, input bit spam, input string tag);
    logic [31:0] m;
    logic [17:0] s0, s1;
    logic [31:0] sig_hold;
    int acc, cyc;
    bit acc_now;
    exp_t e;
    m = seed; s0 = 18'd0; s1 = 18'd0; acc = 0; cyc = 0;
    @(negedge clk); start_v[sel] = 1'b1;
    @(negedge clk); start_v[sel] = 1'b0;
    checks++;
    if (rdy[sel] !== 1'b1 || bsy[sel] !== 1'b1) begin
      errors++; $display("FAIL %s start: in_ready=%b busy=%b want 1 1", tag, rdy[sel], bsy[sel]);
    end
    while (acc < data.size() && cyc < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = data[acc];
      if (spam) start_v[sel] = 1'($urandom_range(0, 1));
      acc_now = in_valid && rdy[sel];
      @(negedge clk); cyc++;
      if (acc_now) begin
        m = mstep(m, data[acc]); s1 |= data[acc]; s0 |= ~data[acc]; acc++;
      end
      if (acc < data.size()) begin
        checks++;
        if (sv[sel] !== 1'b0 || rdy[sel] !== 1'b1) begin
          errors++; $display("FAIL %s run: sig_valid=%b in_ready=%b want 0 1 at beat %0d", tag, sv[sel], rdy[sel], acc);
        end
      end
    end
    start_v[sel] = 1'b0; in_valid = 1'b0;
    if (acc != data.size()) begin
      errors++; $display("FAIL %s timeout: accepted %0d want %0d", tag, acc, data.size());
    end
    e.sig = m; e.mask = s0 & s1; e.cnt = 16'(acc);
    exp_q.push_back(e);
    checks++;
    if (sv[sel] !== 1'b1 || rdy[sel] !== 1'b0 || bsy[sel] !== 1'b1) begin
      errors++; $display("FAIL %s latency: sig_valid=%b in_ready=%b busy=%b want 1 0 1", tag, sv[sel], rdy[sel], bsy[sel]);
    end
    sig_hold = sig[sel];
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = 18'($urandom);
      @(negedge clk);
      checks++;
      if (sv[sel] !== 1'b1 || rdy[sel] !== 1'b0 || sig[sel] !== sig_hold || cnt[sel] !== 16'(acc)) begin
        errors++; $display("FAIL %s hold: sig_valid=%b in_ready=%b sig=%h cnt=%0d want 1 0 %h %0d",
                           tag, sv[sel], rdy[sel], sig[sel], cnt[sel], sig_hold, acc);
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (sig[sel] !== e.sig) begin
      errors++; $display("FAIL %s signature: got %h want %h", tag, sig[sel], e.sig);
    end
    checks++;
    if (msk[sel] !== e.mask) begin
      errors++; $display("FAIL %s toggle_mask: got %h want %h", tag, msk[sel], e.mask);
    end
    checks++;
    if (cnt[sel] !== e.cnt) begin
      errors++; $display("FAIL %s vec_count: got %0d want %0d", tag, cnt[sel], e.cnt);
    end
    sig_ready = 1'b1;
    if (spam) start_v[sel] = 1'b1;
    @(negedge clk);
    sig_ready = 1'b0; start_v[sel] = 1'b0;
    checks++;
    if (sv[sel] !== 1'b0 || rdy[sel] !== 1'b0 || bsy[sel] !== 1'b0 || sig[sel] !== e.sig) begin
      errors++; $display("FAIL %s idle: sig_valid=%b in_ready=%b busy=%b sig=%h want 0 0 0 %h",
                         tag, sv[sel], rdy[sel], bsy[sel], sig[sel], e.sig);
    end
    @(negedge clk);
    checks++;
    if (rdy[sel] !== 1'b0 || bsy[sel] !== 1'b0) begin
      errors++; $display("FAIL %s no_restart: in_ready=%b busy=%b want 0 0", tag, rdy[sel], bsy[sel]);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({rdy[s], sv[s], bsy[s]} !== 3'b000 || sig[s] !== 32'd0 || msk[s] !== 18'd0 || cnt[s] !== 16'd0) begin
        errors++; $display("FAIL reset dut%0d: rdy=%b sv=%b busy=%b sig=%h mask=%h cnt=%0d want all zero",
                           s, rdy[s], sv[s], bsy[s], sig[s], msk[s], cnt[s]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    logic [17:0] d[$];
    d = {18'h00001};
    do_run(0, 32'h0, d, 1'b0, 0, 1'b0, "vec1");
    d = {18'h00001, 18'h3FFFF};
    do_run(1, 32'h0, d, 1'b0, 1, 1'b0, "vec2");
  endtask

  task automatic test_full(input bit spam, input string tag);
    logic [17:0] d[$];
    for (int i = 0; i < 64; i++) d.push_back(ref_net(6'(i)));
    do_run(2, 32'hFFFFFFFF, d, 1'b1, 5, spam, tag);
  endtask

  task automatic test_idle_valid();
    logic [31:0] s0;
    logic [15:0] c0;
    s0 = sig[2]; c0 = cnt[2];
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 18'($urandom);
      @(negedge clk);
      checks++;
      if (rdy[2] !== 1'b0 || cnt[2] !== c0 || sig[2] !== s0) begin
        errors++; $display("FAIL idle_valid: rdy=%b cnt=%0d sig=%h want 0 %0d %h", rdy[2], cnt[2], sig[2], c0, s0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [17:0] d[$];
    @(negedge clk); start_v[2] = 1'b1;
    @(negedge clk); start_v[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = ref_net(6'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy[2], sv[2], bsy[2]} !== 3'b000 || sig[2] !== 32'd0 || msk[2] !== 18'd0 || cnt[2] !== 16'd0) begin
      errors++; $display("FAIL midrun_reset: rdy=%b sv=%b busy=%b sig=%h mask=%h cnt=%0d want all zero",
                         rdy[2], sv[2], bsy[2], sig[2], msk[2], cnt[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) d.push_back(ref_net(6'(i)));
    do_run(2, 32'hFFFFFFFF, d, 1'b0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_small();
    test_full(1'b0, "full64");
    test_idle_valid();
    test_full(1'b1, "start_spam");
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
